// File: rtl/store_queue.sv
// ============================================================================
// Module   : store_queue
// Brief    : In-order committed-store buffer between commit and data memory,
//            with word-granular load-conflict detection.
// Revision : 1.0
// ============================================================================
`default_nettype none

package store_queue_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wrdata;
    logic [3:0]  byteenable;
    logic        uncached;
    logic        write;
  } data_memreq_t;
endpackage

module store_queue
  import store_queue_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  data_memreq_t             memreq,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output data_memreq_t             store_req,
  output logic                     store_valid,
  input  logic                     store_ack,
  input  logic [31:0]              load_addr,
  output logic                     load_conflict
);

  localparam int                c_PTR_W      = $clog2(DEPTH);
  localparam logic [c_PTR_W:0]  c_FULL_COUNT = (c_PTR_W + 1)'(DEPTH);

  data_memreq_t         r_mem [DEPTH];
  logic [c_PTR_W-1:0]   r_head;
  logic [c_PTR_W-1:0]   r_tail;
  logic [c_PTR_W:0]     r_count;

  logic                 w_full;
  logic                 w_empty;
  logic                 w_push_ok;
  logic                 w_pop;
  logic                 w_conflict;
  logic [c_PTR_W-1:0]   w_off;
  logic                 w_unused_load_lsb;

  assign w_full    = (r_count == c_FULL_COUNT);
  assign w_empty   = (r_count == '0);
  assign w_push_ok = push & ~w_full;
  assign w_pop     = store_ack & ~w_empty;

  // Byte offset within the word never participates in conflict detection.
  assign w_unused_load_lsb = &{1'b0, load_addr[1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push_ok) begin
        r_tail <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head <= r_head + 1'b1;
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge clk) begin
    if (!rst && w_push_ok) begin
      r_mem[r_tail] <= memreq;
    end
  end

  always_comb begin
    w_off      = '0;
    w_conflict = w_push_ok && (memreq.addr[31:2] == load_addr[31:2]);
    for (int i = 0; i < DEPTH; i++) begin
      // Slot i is occupied when its distance from head is below occupancy.
      w_off = c_PTR_W'(i) - r_head;
      if (({1'b0, w_off} < r_count) &&
          (r_mem[c_PTR_W'(i)].addr[31:2] == load_addr[31:2])) begin
        w_conflict = 1'b1;
      end
    end
  end

  assign full          = w_full;
  assign empty         = w_empty;
  assign count         = r_count;
  assign store_valid   = ~w_empty;
  assign store_req     = w_empty ? '0 : r_mem[r_head];
  assign load_conflict = w_conflict;

endmodule

`default_nettype wire

// File: tb/tb_store_queue.sv
// ============================================================================
// Module   : tb_store_queue
// Brief    : Directed and randomized self-checking bench for store_queue.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_store_queue;
  import store_queue_pkg::*;

  localparam int DEPTH = 8;

  logic                    clk;
  logic                    rst;
  logic                    push;
  data_memreq_t            memreq;
  logic                    full;
  logic                    empty;
  logic [$clog2(DEPTH):0]  count;
  data_memreq_t            store_req;
  logic                    store_valid;
  logic                    store_ack;
  logic [31:0]             load_addr;
  logic                    load_conflict;

  store_queue #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst           (rst),
    .push          (push),
    .memreq        (memreq),
    .full          (full),
    .empty         (empty),
    .count         (count),
    .store_req     (store_req),
    .store_valid   (store_valid),
    .store_ack     (store_ack),
    .load_addr     (load_addr),
    .load_conflict (load_conflict)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference: the queue contents in program order, head at index 0.
  data_memreq_t mq[$];

  task automatic chk(input string tag, input logic [69:0] obs, input logic [69:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic data_memreq_t mk(input logic [31:0] a, input logic [31:0] d,
                                      input logic [3:0] be);
    data_memreq_t m;
    m.addr       = a;
    m.wrdata     = d;
    m.byteenable = be;
    m.uncached   = 1'b0;
    m.write      = 1'b1;
    return m;
  endfunction

  function automatic data_memreq_t rand_req(input bit small_pool);
    data_memreq_t m;
    if (small_pool)
      m.addr = 32'h2000_0000 | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3));
    else
      m.addr = $urandom;
    m.wrdata     = $urandom;
    m.byteenable = 4'($urandom);
    m.uncached   = 1'($urandom);
    m.write      = 1'($urandom);
    return m;
  endfunction

  // One clock: drive, check visible outputs against the model, clock, update model.
  task automatic step(input bit p, input data_memreq_t m, input bit a,
                      input logic [31:0] la, input bit r);
    bit           exp_conf;
    data_memreq_t exp_req;
    int           sz;
    rst = r; push = p; memreq = m; store_ack = a; load_addr = la;
    #1;
    sz       = mq.size();
    exp_conf = p && (sz < DEPTH) && (m.addr[31:2] == la[31:2]);
    foreach (mq[k]) if (mq[k].addr[31:2] == la[31:2]) exp_conf = 1'b1;
    exp_req  = (sz > 0) ? mq[0] : '0;
    chk("count",    count,         70'(sz));
    chk("full",     full,          70'(sz == DEPTH));
    chk("empty",    empty,         70'(sz == 0));
    chk("valid",    store_valid,   70'(sz > 0));
    chk("req",      store_req,     exp_req);
    chk("conflict", load_conflict, 70'(exp_conf));
    @(posedge clk);
    if (r) begin
      mq.delete();
    end else begin
      if (a && sz > 0) void'(mq.pop_front());
      if (p && sz < DEPTH) mq.push_back(m);
    end
    #1;
  endtask

  task automatic idle(input bit a);
    step(1'b0, '0, a, 32'h0, 1'b0);
  endtask

  initial begin
    data_memreq_t held;
    data_memreq_t first;

    rst = 1'b1; push = 1'b0; memreq = '0; store_ack = 1'b0; load_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    mq.delete();

    // Reset state, then single store with one-cycle latency.
    chk("rst_count", count, 70'(0));
    chk("rst_empty", empty, 70'(1));
    chk("rst_valid", store_valid, 70'(0));
    chk("rst_req",   store_req, 70'(0));
    first = mk(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111);
    step(1'b1, first, 1'b0, 32'h0, 1'b0);
    chk("single_valid", store_valid, 70'(1));
    chk("single_req",   store_req, first);
    idle(1'b1);
    chk("single_empty", empty, 70'(1));
    chk("single_count", count, 70'(0));

    // Fill to full, then a dropped ninth push, then drain in order.
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, mk(32'h4000_0000 + 32'(i * 4), 32'h1111_0000 + 32'(i), 4'hF), 1'b0, 32'h0, 1'b0);
    chk("fill_full", full, 70'(1));
    chk("fill_count", count, 70'(DEPTH));
    step(1'b1, mk(32'h5000_0000, 32'hBAD0_BAD0, 4'hF), 1'b0, 32'h0, 1'b0);
    chk("drop_count", count, 70'(DEPTH));
    step(1'b1, mk(32'h5000_0004, 32'hBAD1_BAD1, 4'hF), 1'b1, 32'h0, 1'b0);
    chk("full_no_bypass", count, 70'(DEPTH - 1));
    while (mq.size() > 0) idle(1'b1);
    chk("drain_empty", empty, 70'(1));

    // Steady occupancy of three with push and ack every cycle across wraps.
    repeat (3) step(1'b1, rand_req(1'b0), 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rand_req(1'b0), 1'b1, 32'h0, 1'b0);
      chk("steady_count", count, 70'(3));
    end
    while (mq.size() > 0) idle(1'b1);

    // Backpressure: head held stable while un-acked.
    step(1'b1, rand_req(1'b0), 1'b0, 32'h0, 1'b0);
    step(1'b1, rand_req(1'b0), 1'b0, 32'h0, 1'b0);
    held = store_req;
    for (int i = 0; i < 5; i++) begin
      idle(1'b0);
      chk("bp_stable", store_req, held);
    end
    idle(1'b1);
    chk("bp_advance_count", count, 70'(1));
    idle(1'b1);

    // Load conflict at word granularity, including the incoming push.
    step(1'b1, mk(32'h1000_0004, 32'hCAFE_0001, 4'b0001), 1'b0, 32'h0, 1'b0);
    load_addr = 32'h1000_0007; #1;
    chk("conf_same_word", load_conflict, 70'(1));
    load_addr = 32'h1000_0008; #1;
    chk("conf_next_word", load_conflict, 70'(0));
    push = 1'b1; memreq = mk(32'h1000_0008, 32'h0, 4'b1000); #1;
    chk("conf_incoming", load_conflict, 70'(1));
    push = 1'b0; store_ack = 1'b1; load_addr = 32'h1000_0004; #1;
    chk("conf_acked_head", load_conflict, 70'(1));
    idle(1'b1);

    // Reset with five entries and an un-acked head.
    for (int i = 0; i < 5; i++) step(1'b1, rand_req(1'b0), 1'b0, 32'h0, 1'b0);
    step(1'b0, '0, 1'b0, 32'h0, 1'b1);
    chk("midrst_count", count, 70'(0));
    chk("midrst_valid", store_valid, 70'(0));
    step(1'b1, first, 1'b0, 32'h0, 1'b0);
    chk("post_rst_req", store_req, first);
    idle(1'b1);

    // Randomized traffic with a small address pool to provoke conflicts.
    for (int i = 0; i < 400; i++) begin
      data_memreq_t la;
      la = rand_req(1'b1);
      step(1'($urandom_range(0, 99) < 60), rand_req(1'b1),
           1'($urandom_range(0, 99) < 45), la.addr,
           ($urandom_range(0, 99) == 0));
    end
    while (mq.size() > 0) idle(1'b1);
    chk("final_empty", empty, 70'(1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
